poly_tone_synth: RTL and testbench
==================================

Name: poly_tone_synth

Overview:
- Polyphonic successor to the single-voice keyboard tone generator.
- Parses the raw PS/2 byte stream (make, break, and extended prefixes) and allocates up to VOICES simultaneous square-wave voices, one per held key.
- Mixes the voices into one signed sample and feeds the audio codec through its allowed/write handshake.
- Sits between the PS/2 controller and the audio codec in the piano top level.

Parameters:
VOICES, 4, number of simultaneous voices (1..8)
CNT_W, 18, half-period counter width; must hold 191131
AMP, 10000000, full-scale amplitude; each voice contributes +/-(AMP/VOICES), integer division

Ports:
clock  input  1  system clock, 50 MHz
reset  input  1  synchronous, active-high
ps2_key_data  input  8  received PS/2 byte, valid when strobe high
ps2_key_pressed  input  1  one-cycle strobe per received byte
audio_out_allowed  input  1  codec FIFO can accept a sample
write_audio_out  output  1  sample write strobe to codec
audio_out  output  32  signed mixed sample, same value to left and right
voices_active  output  VOICES  bit i high while voice i is allocated

Behaviour:
- Reset (synchronous, active-high, clock clock): all voices free, counters 0, phases 0; parser in IDLE; audio_out=0; write_audio_out=0; voices_active=0. Reset mid-note silences immediately at the next edge.
- Parser FSM, advances only on strobe cycles:
  - IDLE: byte F0 -> BRK; byte E0 -> EXT; any other byte -> make(byte), stay IDLE.
  - BRK: byte -> break(byte), go to IDLE.
  - EXT: F0 -> stay EXT; any other byte is discarded -> IDLE. Extended keys produce no sound.
- Lookup: 36-entry combinational table, scan code -> half-period count = round(50e6 / (2*f)), notes C3..B5.
  - Anchors: 0x15 -> 191131 (C3), 0x1A -> 56818 (A4), 0x22 -> 50618 (B4), 0x49 -> 25309 (B5).
  - Codes not in the table: make and break are both ignored.
- make(code):
  - If code is already held by a voice: no change (typematic repeat).
  - Else: allocate the lowest-index free voice. Store code and half-period; counter=0, phase=0; voices_active bit rises on the cycle after the strobe.
  - If no voice is free: see VOICE_STEAL_EN.
- break(code): free every voice holding code. Its bit falls on the next cycle and its counter and phase clear. A break for an unheld code is a no-op.
- Voice i, every cycle while allocated:
  - If counter == half-period: counter <= 0 and phase toggles.
  - Else counter increments.
  - Output period = 2*(half-period+1) cycles.
- Mixer:
  - Each active voice contributes +AMP/VOICES when phase=1 and -AMP/VOICES when phase=0.
  - Free voices contribute 0.
  - Signed 32-bit sum; no overflow possible since |sum| <= AMP.
- Codec handshake:
  - Each cycle, audio_out <= mix sum (registered), so audio_out lags voice state by 1 cycle.
  - write_audio_out <= audio_out_allowed, also registered.
  - When allowed is low: no write, and the sample is simply dropped (the generator never stalls).

Optional Feature:
VOICE_STEAL_EN
- Defined: a 3-bit round-robin pointer (mod VOICES) tracks the next steal victim. A make with all voices busy reassigns voice[pointer] to the new code (counter=0, phase=0), then increments the pointer. The pointer resets to 0.
- Undefined: a make with all voices busy is dropped; no state changes.

Test Plan:
- Reset, then send 0x1A -> voices_active=0001. Phase of voice 0 toggles every 56819 cycles. audio_out alternates -2500000/+2500000 with period 113638 cycles.
- Send 0x1A, 0x15, then F0 0x1A -> voices_active 0001 -> 0011 -> 0010. audio_out returns to +/-2500000 at C3 rate after the break.
- Hold 4 keys (0x15 0x1D 0x24 0x2C), then send 0x35 -> without macro: voices_active=1111, 0x35 dropped. With VOICE_STEAL_EN: voice 0 now plays 113636 half-period.
- Send E0 0x75, then E0 F0 0x75 -> no voice allocated, parser back in IDLE; a following 0x1A allocates voice 0.
- Repeat 0x1A x3 -> only voice 0 active. Unknown code 0x0D -> ignored.
- Hold audio_out_allowed=0 for 100 cycles -> write_audio_out=0 throughout. Raise it -> write_audio_out=1 one cycle later. Assert reset mid-note -> audio_out=0 and voices_active=0 after one edge.

Source files
------------

// File: rtl/poly_tone_synth.sv
// Polyphonic PS/2 keyboard tone generator: parses make/break/extended bytes, runs up to VOICES
// square-wave voices and streams their mix to the audio codec. Optional macro: VOICE_STEAL_EN.
module poly_tone_synth #(
  parameter int unsigned VOICES = 4,
  parameter int unsigned CNT_W  = 18,
  parameter int          AMP    = 10000000
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [7:0]        ps2_key_data,
  input  logic              ps2_key_pressed,
  input  logic              audio_out_allowed,
  output logic              write_audio_out,
  output logic [31:0]       audio_out,
  output logic [VOICES-1:0] voices_active
);

  localparam int STEP = AMP / int'(VOICES);

  typedef enum logic [1:0] {StIdle, StBrk, StExt} parse_state_e;

  parse_state_e state_q, state_d;
  logic         make_en, brk_en;
  logic         note_valid;
  logic [CNT_W-1:0] note_hp;

  logic [VOICES-1:0]            on_q, on_d, phase_q, phase_d, held;
  logic [VOICES-1:0][7:0]       code_q, code_d;
  logic [VOICES-1:0][CNT_W-1:0] hp_q, hp_d, cnt_q, cnt_d;
  logic                         alloc_done;
  logic signed [31:0]           mix;

`ifdef VOICE_STEAL_EN
  logic [2:0] steal_q, steal_d;
`endif

  // Parser: only strobe cycles advance the state
  always_comb begin
    state_d = state_q;
    make_en = 1'b0;
    brk_en  = 1'b0;
    if (ps2_key_pressed) begin
      unique case (state_q)
        StIdle: begin
          if (ps2_key_data == 8'hF0)      state_d = StBrk;
          else if (ps2_key_data == 8'hE0) state_d = StExt;
          else                            make_en = 1'b1;
        end
        StBrk: begin
          brk_en  = 1'b1;
          state_d = StIdle;
        end
        StExt: begin
          if (ps2_key_data != 8'hF0) state_d = StIdle;
        end
        default: state_d = StIdle;
      endcase
    end
  end

  // Scan code -> half-period count, C3..B5
  always_comb begin
    note_valid = 1'b1;
    note_hp    = '0;
    case (ps2_key_data)
      8'h15: note_hp = CNT_W'(191131); // C3
      8'h1E: note_hp = CNT_W'(180375);
      8'h1D: note_hp = CNT_W'(170300);
      8'h26: note_hp = CNT_W'(160668);
      8'h24: note_hp = CNT_W'(151699);
      8'h2D: note_hp = CNT_W'(143184);
      8'h2E: note_hp = CNT_W'(135135);
      8'h2C: note_hp = CNT_W'(127551);
      8'h36: note_hp = CNT_W'(120366);
      8'h35: note_hp = CNT_W'(113636);
      8'h3D: note_hp = CNT_W'(107250);
      8'h3C: note_hp = CNT_W'(101256);
      8'h43: note_hp = CNT_W'(95566);  // C4
      8'h46: note_hp = CNT_W'(90188);
      8'h44: note_hp = CNT_W'(85121);
      8'h45: note_hp = CNT_W'(80360);
      8'h4D: note_hp = CNT_W'(75850);
      8'h1C: note_hp = CNT_W'(71592);
      8'h1B: note_hp = CNT_W'(67568);
      8'h23: note_hp = CNT_W'(63776);
      8'h2B: note_hp = CNT_W'(60197);
      8'h1A: note_hp = CNT_W'(56818);  // A4
      8'h34: note_hp = CNT_W'(53625);
      8'h22: note_hp = CNT_W'(50618);
      8'h21: note_hp = CNT_W'(47774);  // C5
      8'h33: note_hp = CNT_W'(45094);
      8'h2A: note_hp = CNT_W'(42568);
      8'h3B: note_hp = CNT_W'(40174);
      8'h32: note_hp = CNT_W'(37919);
      8'h31: note_hp = CNT_W'(35791);
      8'h42: note_hp = CNT_W'(33784);
      8'h3A: note_hp = CNT_W'(31888);
      8'h4B: note_hp = CNT_W'(30099);
      8'h41: note_hp = CNT_W'(28409);
      8'h4C: note_hp = CNT_W'(26815);
      8'h49: note_hp = CNT_W'(25309);  // B5
      default: note_valid = 1'b0;
    endcase
  end

  always_comb begin
    on_d       = on_q;
    phase_d    = phase_q;
    code_d     = code_q;
    hp_d       = hp_q;
    cnt_d      = cnt_q;
    held       = '0;
    alloc_done = 1'b0;
`ifdef VOICE_STEAL_EN
    steal_d    = steal_q;
`endif
    for (int i = 0; i < int'(VOICES); i++) begin
      held[i] = on_q[i] && (code_q[i] == ps2_key_data);
      if (on_q[i]) begin
        if (cnt_q[i] == hp_q[i]) begin
          cnt_d[i]   = '0;
          phase_d[i] = ~phase_q[i];
        end else begin
          cnt_d[i] = cnt_q[i] + CNT_W'(1);
        end
      end
    end

    // Typematic repeats of a held key fall through without touching any voice
    if (make_en && note_valid && (held == '0)) begin
      for (int i = 0; i < int'(VOICES); i++) begin
        if (!alloc_done && !on_q[i]) begin
          on_d[i]    = 1'b1;
          code_d[i]  = ps2_key_data;
          hp_d[i]    = note_hp;
          cnt_d[i]   = '0;
          phase_d[i] = 1'b0;
          alloc_done = 1'b1;
        end
      end
`ifdef VOICE_STEAL_EN
      if (!alloc_done) begin
        for (int i = 0; i < int'(VOICES); i++) begin
          if (3'(i) == steal_q) begin
            code_d[i]  = ps2_key_data;
            hp_d[i]    = note_hp;
            cnt_d[i]   = '0;
            phase_d[i] = 1'b0;
          end
        end
        steal_d = (steal_q == 3'(VOICES - 1)) ? 3'd0 : steal_q + 3'd1;
      end
`endif
    end

    if (brk_en && note_valid) begin
      for (int i = 0; i < int'(VOICES); i++) begin
        if (held[i]) begin
          on_d[i]    = 1'b0;
          cnt_d[i]   = '0;
          phase_d[i] = 1'b0;
        end
      end
    end
  end

  always_comb begin
    mix = '0;
    for (int i = 0; i < int'(VOICES); i++) begin
      if (on_q[i]) mix = phase_q[i] ? mix + STEP : mix - STEP;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q         <= StIdle;
      on_q            <= '0;
      phase_q         <= '0;
      code_q          <= '0;
      hp_q            <= '0;
      cnt_q           <= '0;
      audio_out       <= '0;
      write_audio_out <= 1'b0;
`ifdef VOICE_STEAL_EN
      steal_q         <= 3'd0;
`endif
    end else begin
      state_q         <= state_d;
      on_q            <= on_d;
      phase_q         <= phase_d;
      code_q          <= code_d;
      hp_q            <= hp_d;
      cnt_q           <= cnt_d;
      audio_out       <= mix;
      write_audio_out <= audio_out_allowed;
`ifdef VOICE_STEAL_EN
      steal_q         <= steal_d;
`endif
    end
  end

  assign voices_active = on_q;

endmodule

// File: tb/tb_poly_tone_synth.sv
// Bench for poly_tone_synth: directed key scenarios plus random PS/2 traffic, checked every
// cycle against a time-based voice model (phase derived from elapsed cycles since key press).
module tb_poly_tone_synth;

  localparam int VOICES = 4;
  localparam int CNT_W  = 18;
  localparam int AMP    = 10000000;
  localparam int STEP   = AMP / VOICES;

  logic              clock;
  logic              reset;
  logic [7:0]        ps2_key_data;
  logic              ps2_key_pressed;
  logic              audio_out_allowed;
  logic              write_audio_out;
  logic [31:0]       audio_out;
  logic [VOICES-1:0] voices_active;

  poly_tone_synth #(
    .VOICES (VOICES),
    .CNT_W  (CNT_W),
    .AMP    (AMP)
  ) dut (
    .clock             (clock),
    .reset             (reset),
    .ps2_key_data      (ps2_key_data),
    .ps2_key_pressed   (ps2_key_pressed),
    .audio_out_allowed (audio_out_allowed),
    .write_audio_out   (write_audio_out),
    .audio_out         (audio_out),
    .voices_active     (voices_active)
  );

  initial clock = 1'b0;
  always #10 clock = ~clock;

  int checks   = 0;
  int failures = 0;

  // Reference model state: which key each voice holds and the cycle it started on
  int         hp_tab [256];
  logic [7:0] key_codes [36];
  bit         m_on    [VOICES];
  logic [7:0] m_code  [VOICES];
  int         m_start [VOICES];
  int         m_state;  // 0 idle, 1 after F0, 2 after E0
  int         m_ptr;
  int         edge_n;
  int         exp_audio;
  bit         exp_write;
  bit         model_valid = 1'b0;

  task automatic check(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [VOICES-1:0] exp_active();
    logic [VOICES-1:0] a;
    a = '0;
    for (int i = 0; i < VOICES; i++) a[i] = m_on[i];
    return a;
  endfunction

  function automatic int model_mix();
    int s;
    int hp;
    s = 0;
    for (int i = 0; i < VOICES; i++) begin
      if (m_on[i]) begin
        hp = hp_tab[m_code[i]];
        s += (((edge_n - m_start[i]) / (hp + 1)) % 2 == 1) ? STEP : -STEP;
      end
    end
    return s;
  endfunction

  task automatic model_make(input logic [7:0] b, input int t);
    bit done;
    done = 1'b0;
    if (hp_tab[b] == 0) return;
    for (int i = 0; i < VOICES; i++) if (m_on[i] && m_code[i] == b) return;
    for (int i = 0; i < VOICES; i++) begin
      if (!done && !m_on[i]) begin
        m_on[i] = 1'b1; m_code[i] = b; m_start[i] = t; done = 1'b1;
      end
    end
`ifdef VOICE_STEAL_EN
    if (!done) begin
      m_code[m_ptr] = b; m_start[m_ptr] = t;
      m_ptr = (m_ptr + 1) % VOICES;
    end
`endif
  endtask

  // Advance the model across the coming clock edge using the inputs it will sample
  task automatic model_advance();
    if (reset) begin
      for (int i = 0; i < VOICES; i++) m_on[i] = 1'b0;
      m_state = 0; m_ptr = 0; exp_audio = 0; exp_write = 1'b0;
      model_valid = 1'b1;
    end else begin
      exp_audio = model_mix();
      exp_write = audio_out_allowed;
      if (ps2_key_pressed) begin
        case (m_state)
          0: begin
            if (ps2_key_data == 8'hF0)      m_state = 1;
            else if (ps2_key_data == 8'hE0) m_state = 2;
            else                            model_make(ps2_key_data, edge_n + 1);
          end
          1: begin
            if (hp_tab[ps2_key_data] != 0)
              for (int i = 0; i < VOICES; i++)
                if (m_on[i] && m_code[i] == ps2_key_data) m_on[i] = 1'b0;
            m_state = 0;
          end
          default: if (ps2_key_data != 8'hF0) m_state = 0;
        endcase
      end
    end
    edge_n++;
  endtask

  initial begin : compare
    forever begin
      @(negedge clock);
      if (model_valid) begin
        check("audio_out", longint'($signed(audio_out)), longint'(exp_audio));
        check("write_audio_out", longint'(write_audio_out), longint'(exp_write));
        check("voices_active", longint'(voices_active), longint'(exp_active()));
      end
      model_advance();
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic send(input logic [7:0] b);
    ps2_key_data    = b;
    ps2_key_pressed = 1'b1;
    tick(1);
    ps2_key_pressed = 1'b0;
    ps2_key_data    = 8'($urandom);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick(2);
    reset = 1'b0;
  endtask

  logic [7:0] pool [9];
  logic [7:0] k;

  initial begin : driver
    real f;
    reset             = 1'b1;
    ps2_key_data      = 8'h00;
    ps2_key_pressed   = 1'b0;
    audio_out_allowed = 1'b1;
    edge_n            = 0;
    m_state           = 0;
    m_ptr             = 0;
    for (int i = 0; i < 256; i++) hp_tab[i] = 0;
    key_codes = '{8'h15, 8'h1E, 8'h1D, 8'h26, 8'h24, 8'h2D, 8'h2E, 8'h2C, 8'h36, 8'h35,
                  8'h3D, 8'h3C, 8'h43, 8'h46, 8'h44, 8'h45, 8'h4D, 8'h1C, 8'h1B, 8'h23,
                  8'h2B, 8'h1A, 8'h34, 8'h22, 8'h21, 8'h33, 8'h2A, 8'h3B, 8'h32, 8'h31,
                  8'h42, 8'h3A, 8'h4B, 8'h41, 8'h4C, 8'h49};
    // Equal temperament from A4=440 Hz, frequency rounded to 0.1 Hz, then round(25e6/f)
    for (int n = 0; n < 36; n++) begin
      f = 440.0 * $pow(2.0, real'(n - 21) / 12.0);
      f = $floor(f * 10.0 + 0.5) / 10.0;
      hp_tab[key_codes[n]] = int'($floor(25.0e6 / f + 0.5));
    end
    check("hp C3", hp_tab[8'h15], 191131);
    check("hp A3", hp_tab[8'h35], 113636);
    check("hp A4", hp_tab[8'h1A], 56818);
    check("hp B4", hp_tab[8'h22], 50618);
    check("hp B5", hp_tab[8'h49], 25309);
    check("hp unknown", hp_tab[8'h0D], 0);

    tick(3);
    check("reset active", voices_active, 0);
    check("reset audio", audio_out, 0);
    check("reset write", write_audio_out, 0);
    reset = 1'b0;
    tick(2);

    send(8'h1A);
    check("A4 alloc", voices_active, 4'b0001);
    tick(1);
    check("A4 low phase", longint'($signed(audio_out)), -2500000);

    send(8'h15);
    check("C3 alloc", voices_active, 4'b0011);
    send(8'hF0); send(8'h1A);
    check("A4 break", voices_active, 4'b0010);
    tick(2);
    check("C3 alone", longint'($signed(audio_out)), -2500000);

    do_reset();
    send(8'h15); send(8'h1D); send(8'h24); send(8'h2C); send(8'h35);
    check("four held", voices_active, 4'b1111);
    send(8'hF0); send(8'h15);
`ifdef VOICE_STEAL_EN
    check("C3 stolen", voices_active, 4'b1111);
    send(8'hF0); send(8'h35);
    check("A3 on voice0", voices_active, 4'b1110);
`else
    check("C3 freed", voices_active, 4'b1110);
    send(8'hF0); send(8'h35);
    check("A3 dropped", voices_active, 4'b1110);
`endif

    do_reset();
    send(8'hE0); send(8'h75); send(8'hE0); send(8'hF0); send(8'h75);
    check("extended silent", voices_active, 0);
    send(8'h1A);
    check("after extended", voices_active, 4'b0001);

    do_reset();
    send(8'h1A); send(8'h1A); send(8'h1A);
    check("typematic", voices_active, 4'b0001);
    send(8'h0D); send(8'hF0); send(8'h0D);
    check("unknown code", voices_active, 4'b0001);

    audio_out_allowed = 1'b0;
    tick(100);
    check("write held low", write_audio_out, 0);
    audio_out_allowed = 1'b1;
    tick(1);
    check("write resumes", write_audio_out, 1);

    tick(5);
    reset = 1'b1;
    tick(1);
    check("midnote reset audio", audio_out, 0);
    check("midnote reset active", voices_active, 0);
    reset = 1'b0;
    tick(1);

    pool = '{8'h15, 8'h1D, 8'h24, 8'h2C, 8'h35, 8'h1A, 8'h22, 8'h49, 8'h0D};
    for (int e = 0; e < 400; e++) begin
      audio_out_allowed = ($urandom % 4) != 0;
      k = pool[$urandom % 9];
      case ($urandom % 10)
        0, 1, 2, 3, 4: send(k);
        5, 6, 7: begin send(8'hF0); send(k); end
        8: begin
          send(8'hE0);
          if ($urandom % 2 == 1) send(8'hF0);
          send(k);
        end
        default: begin
          if ($urandom % 20 == 0) do_reset();
          else tick(1 + $urandom % 8);
        end
      endcase
      tick($urandom % 6);
    end

    audio_out_allowed = 1'b1;
    do_reset();
    send(8'h49);
    tick(25310);
    check("B5 before toggle", longint'($signed(audio_out)), -2500000);
    tick(1);
    check("B5 after toggle", longint'($signed(audio_out)), 2500000);
    tick(3);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
